// File: rtl/rand_share_arb.sv
// rand_share_arb
// Shares one 8-bit Fibonacci LFSR among NREQ requesters. Each grant hands
// out exactly one fresh random byte with a one-cycle ack pulse, and the LFSR
// advances exactly once per grant.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   req        level request per client, held until ack
//   ack        one-hot, one-cycle grant pulse (rand_out valid in same cycle)
//   rand_out   delivered random byte, holds between grants
//   seed_load  load seed_in into the LFSR at the next edge
//   seed_in    seed value (0 is legal, recovers to SEED on the next step)
//   busy       high whenever the FSM is not in IDLE
//
// Configuration:
//   RAND_FIXED_PRIO_EN  when defined, the lowest-index request always wins
//                       and no round-robin pointer exists. Default (undefined)
//                       is round-robin starting from rr_ptr.
//
// Parameters: NREQ (2..8), SEED (reset/lockup value), GAP_CYCLES (0..15).

module rand_share_arb #(
  parameter int unsigned NREQ       = 4,
  parameter logic [7:0]  SEED       = 8'd10,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [7:0]      rand_out,
  input  logic            seed_load,
  input  logic [7:0]      seed_in,
  output logic            busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;
  // GAP is entered with GAP_CYCLES-1 so that it lasts exactly GAP_CYCLES cycles.
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // One LFSR step; the all-zero lockup state is recovered by reloading SEED.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = SEED;
    end else begin
      r = {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      rand_q, rand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic            win_vld_c;
  logic [PW-1:0]   win_idx_c;

`ifdef RAND_FIXED_PRIO_EN
  // Fixed priority: lowest asserted index wins.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[PW'(i)]) begin
        win_vld_c = 1'b1;
        win_idx_c = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin: first set request searching upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = i + 32'(rr_ptr_q);
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_vld_c && req[PW'(idx)]) begin
        win_vld_c = 1'b1;
        win_idx_c = PW'(idx);
      end
    end
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ack_d   = '0;
    rand_d  = rand_q;
    cnt_d   = cnt_q;
`ifndef RAND_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_vld_c) begin
          ack_d[win_idx_c] = 1'b1;
          rand_d           = lfsr_q;
          lfsr_d           = lfsr_step(lfsr_q);
          state_d          = ST_GRANT;
`ifndef RAND_FIXED_PRIO_EN
          if (win_idx_c == PW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = win_idx_c + PW'(1);
          end
`endif
        end
      end

      ST_GRANT: begin
        if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end
      end

      ST_GAP: begin
        // Requests are ignored here.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A seed load wins over a coinciding step; the grant still sees the old value.
    if (seed_load) begin
      lfsr_d = seed_in;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      ack_q   <= '0;
      rand_q  <= 8'h00;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ack_q   <= ack_d;
      rand_q  <= rand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifndef RAND_FIXED_PRIO_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign ack      = ack_q;
  assign rand_out = rand_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rand_share_arb.sv
// Self-checking bench for rand_share_arb (NREQ=4, SEED=0x0A, GAP_CYCLES=1).
// Expected grants are queued when stimulus is driven and compared by a
// negedge monitor whenever an ack pulse appears.

module tb_rand_share_arb;

  localparam int unsigned NREQ = 4;
  localparam logic [7:0]  SEED = 8'h0A;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ack;
  logic [7:0]      rand_out;
  logic            seed_load = 1'b0;
  logic [7:0]      seed_in = 8'h00;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [7:0]      data;
  } exp_t;

  exp_t exp_q[$];

  rand_share_arb #(
    .NREQ      (NREQ),
    .SEED      (SEED),
    .GAP_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack      (ack),
    .rand_out (rand_out),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR, written straight from the polynomial description.
  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    logic fb;
    if (v == 8'h00) return SEED;
    fb = v[4] ^ v[3] ^ v[2] ^ v[0];
    return {fb, v[7:1]};
  endfunction

  // Scoreboard monitor: every ack pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && ack !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack ack=%b rand_out=%h (no grant expected)", ack, rand_out);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || rand_out !== e.data) begin
          failures++;
          $display("FAIL grant ack=%b rand_out=%h expected ack=%b rand_out=%h",
                   ack, rand_out, e.ack, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [NREQ-1:0] a, input logic [7:0] d);
    exp_t e;
    e.ack  = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(1);
    exp_q.delete();
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack !== '0) begin
        a  = ack;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout ack=%b expected a pulse within 20 cycles", ack);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%b expected 0 within 20 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    checks++;
    if (ack !== '0) begin failures++; $display("FAIL reset_ack ack=%b expected 0", ack); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b expected 0", busy); end
    checks++;
    if (rand_out !== 8'h00) begin failures++; $display("FAIL reset_rand rand_out=%h expected 00", rand_out); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_req();
    logic [NREQ-1:0] a;
    bit ok;
    do_reset();
    push(4'b0001, 8'h0A);
    req = 4'b0001;
    tick(1);
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL latency ack=%b expected 0001 one cycle after req", ack); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL grant_busy busy=%b expected 1", busy); end
    req = '0;
    wait_idle();
    push(4'b0001, 8'h85);
    req = 4'b0001;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
    tick(3);
    checks++;
    if (rand_out !== 8'h85) begin failures++; $display("FAIL rand_hold rand_out=%h expected 85", rand_out); end
    push(4'b0001, 8'h42);
    req = 4'b0001;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
  endtask

  task automatic test_all_req();
    logic [NREQ-1:0] a;
    bit ok;
    int unsigned last;
    do_reset();
    push(4'b0001, 8'h0A);
    push(4'b0010, 8'h85);
    push(4'b0100, 8'h42);
    push(4'b1000, 8'h21);
    last = 0;
    req  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, ok);
      if (!ok) break;
      if (k > 0) begin
        checks++;
        if (cyc - last != 3) begin
          failures++;
          $display("FAIL grant_spacing gap=%0d expected 3", cyc - last);
        end
      end
      last = cyc;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_grant busy=%b expected 1", busy); end
      req = req & ~a;
      tick(1);
      checks++;
      if (busy !== 1'b1 || ack !== '0) begin
        failures++;
        $display("FAIL gap_state busy=%b ack=%b expected busy=1 ack=0000", busy, ack);
      end
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_seed_zero();
    logic [NREQ-1:0] a;
    bit ok;
    do_reset();
    seed_load = 1'b1;
    seed_in   = 8'h00;
    tick(1);
    seed_load = 1'b0;
    push(4'b0010, 8'h00);
    req = 4'b0010;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
    push(4'b0100, 8'h0A);
    req = 4'b0100;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
  endtask

  task automatic test_seed_coincide();
    logic [NREQ-1:0] a;
    bit ok;
    do_reset();
    push(4'b0001, 8'h0A);
    req       = 4'b0001;
    seed_load = 1'b1;
    seed_in   = 8'h55;
    tick(1);
    seed_load = 1'b0;
    req       = '0;
    wait_idle();
    push(4'b0010, 8'h55);
    req = 4'b0010;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
    push(4'b0100, 8'hAA);
    req = 4'b0100;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
  endtask

  task automatic test_async_reset();
    logic [NREQ-1:0] a;
    bit ok;
    do_reset();
    req = 4'b0001;
    tick(1);
    checks++;
    if (ack !== 4'b0001 || rand_out !== 8'h0A) begin
      failures++;
      $display("FAIL pre_kill ack=%b rand_out=%h expected 0001/0a", ack, rand_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack !== '0 || busy !== 1'b0 || rand_out !== 8'h00) begin
      failures++;
      $display("FAIL async_kill ack=%b busy=%b rand_out=%h expected 0000/0/00", ack, busy, rand_out);
    end
    req = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
    push(4'b0001, 8'h0A);
    req = 4'b0001;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] winners [4];
    logic [7:0] v;
    bit ok;
`ifdef RAND_FIXED_PRIO_EN
    winners = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    winners = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
    do_reset();
    v = SEED;
    for (int k = 0; k < 4; k++) begin
      push(winners[k], v);
      v = lfsr_model(v);
    end
    push(4'b1000, v);
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, ok);
      if (!ok) break;
      req = req & ~a;
      tick(1);
      req = req | a;
    end
    req = 4'b1000;
    wait_ack(a, ok);
    req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_all_req();
    test_seed_zero();
    test_seed_coincide();
    test_async_reset();
    test_back_to_back();
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_share_arb.md
Name: rand_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit Fibonacci LFSR random source among NREQ requesters.
- Each granted request gets exactly one fresh random byte, with a one-cycle ack pulse, and the LFSR advances exactly once per grant.
- Sits between game/display logic clients (dice, pattern generators, hex display drivers) and the random source. It replaces free-running per-client LFSRs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SEED, 8'd10, reset/lockup-recovery value of the LFSR.
- GAP_CYCLES, 1, idle cycles forced after each grant before the next arbitration (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  level request per client; held until ack.
- ack  output  NREQ  one-hot, one-cycle pulse; rand_out is valid in the same cycle.
- rand_out  output  8  delivered random byte; holds its value between grants.
- seed_load  input  1  load seed_in into the LFSR at the next edge.
- seed_in  input  8  seed value.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr=SEED, rr_ptr=0, ack=0, rand_out=8'h00, gap counter=0, busy=0. Outputs drop immediately, without waiting for clk. This holds mid-grant: an ack in flight is killed.
- LFSR step: if lfsr==0, next=SEED. Otherwise next={lfsr[4]^lfsr[3]^lfsr[2]^lfsr[0], lfsr[7:1]}.
- FSM states: IDLE, GRANT, GAP.
- IDLE: if any req bit is high at the clock edge, pick the winner. The winner is the first set bit searching from rr_ptr upward, wrapping modulo NREQ. At that edge:
  - registered ack[winner] <= 1;
  - rand_out <= lfsr (pre-step value);
  - lfsr <= step(lfsr);
  - rr_ptr <= (winner+1) mod NREQ;
  - state <= GRANT.
  If no req bit is set, stay in IDLE with nothing changing.
- Latency: req first high in cycle t → ack visible in cycle t+1.
- GRANT (one cycle, ack high): at its edge ack <= 0. Then state <= GAP with counter=GAP_CYCLES-1, or state <= IDLE if GAP_CYCLES==0.
- GAP: ack=0, requests are ignored, and the counter decrements. Move to IDLE when the counter reaches 0.
- Steady-state grant period is 2+GAP_CYCLES cycles.
- Requester rule: a client must drop req in the cycle after its ack, or it is treated as a new request. Because rr_ptr moved past it, it waits for all other pending clients first.
- Starvation: any held req is acked within NREQ grants.
- seed_load is accepted in any state and takes priority over the step at the same edge: lfsr <= seed_in and that step is discarded. A coinciding grant still delivers the pre-load lfsr value.
- seed_in=0 is legal. The next grant delivers 0x00, and the following step recovers to SEED.
- req bits beyond the winner in the same cycle are not lost; they are served in later rounds.

Optional Feature:
- Macro RAND_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index asserted req always wins, and rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.
- All other timing is identical in both modes.

Test Plan:
- Reset, then req=4'b0001 held for 1 cycle → ack=4'b0001 one cycle later, rand_out=0x0A. Next single req0 → rand_out=0x85, then 0x42.
- Reset, req=4'b1111 held continuously (GAP_CYCLES=1), each client dropping its req after its ack → acks in order 0,1,2,3, spaced 3 cycles apart, values 0x0A,0x85,0x42,0x21. busy stays high throughout grant+gap.
- In IDLE, seed_load=1 with seed_in=0x00, then req1 → ack[1] with rand_out=0x00. Next req2 → rand_out=0x0A (lockup recovery).
- seed_load with seed_in=0x55 in the same edge as a grant → ack delivers the old lfsr value. The next grant delivers 0x55.
- Assert rst asynchronously while ack is high → ack, busy and rand_out go to 0 immediately. After release, req0 → 0x0A.
- With RAND_FIXED_PRIO_EN defined, req0 and req3 held, req0 re-asserted after each ack → req0 wins every time and ack[3] never pulses until req0 drops.
